// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_pipe
// Brief    : 3-stage pipelined binary floating-point multiplier (RNE, DAZ/FTZ).
//            Define FP_MUL_PIPE_FLAGS_EN to build the exception-flag datapath.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic [3:0]             flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int c_xw = EXP_W + 2;
    localparam int c_pw = 2*MAN_W + 2;

    localparam logic [1:0] c_kind_num  = 2'd0;
    localparam logic [1:0] c_kind_zero = 2'd1;
    localparam logic [1:0] c_kind_inf  = 2'd2;
    localparam logic [1:0] c_kind_nan  = 2'd3;

    localparam logic [c_xw-1:0] c_exp_max = c_xw'((1 << EXP_W) - 1);

    logic w_stall;
    logic r_s1_valid, r_s2_valid, r_out_valid;
    logic [W-1:0] r_y;

    assign w_stall   = r_out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_out_valid;
    assign y         = r_y;

    // ---------------- S1: unpack / classify ----------------
    logic             w_a_sign, w_b_sign;
    logic [EXP_W-1:0] w_a_exp, w_b_exp;
    logic [MAN_W-1:0] w_a_man, w_b_man;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic             w_inf_x_zero;
    logic [1:0]       w_kind;

    assign {w_a_sign, w_a_exp, w_a_man} = a;
    assign {w_b_sign, w_b_exp, w_b_man} = b;

    // Subnormals collapse into zero here, so exp==0 alone means zero.
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_inf  = (&w_a_exp) & ~(|w_a_man);
    assign w_b_inf  = (&w_b_exp) & ~(|w_b_man);
    assign w_a_nan  = (&w_a_exp) & (|w_a_man);
    assign w_b_nan  = (&w_b_exp) & (|w_b_man);
    assign w_inf_x_zero = (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);

    always_comb begin
        w_kind = c_kind_num;
        if (w_a_nan | w_b_nan | w_inf_x_zero)
            w_kind = c_kind_nan;
        else if (w_a_inf | w_b_inf)
            w_kind = c_kind_inf;
        else if (w_a_zero | w_b_zero)
            w_kind = c_kind_zero;
    end

    logic            r_s1_sign;
    logic [c_xw-1:0] r_s1_exp;
    logic [MAN_W:0]  r_s1_ma, r_s1_mb;
    logic [1:0]      r_s1_kind;

    // ---------------- S2: significand product ----------------
    logic            r_s2_sign;
    logic [c_xw-1:0] r_s2_exp;
    logic [c_pw-1:0] r_s2_prod;
    logic [1:0]      r_s2_kind;

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_s1_sign <= w_a_sign ^ w_b_sign;
            r_s1_exp  <= c_xw'(w_a_exp) + c_xw'(w_b_exp) - c_xw'(BIAS);
            r_s1_ma   <= {1'b1, w_a_man};
            r_s1_mb   <= {1'b1, w_b_man};
            r_s1_kind <= w_kind;
            r_s2_sign <= r_s1_sign;
            r_s2_exp  <= r_s1_exp;
            r_s2_prod <= c_pw'(r_s1_ma) * c_pw'(r_s1_mb);
            r_s2_kind <= r_s1_kind;
        end
    end

    // ---------------- S3: normalise / round / pack ----------------
    logic             w_norm, w_guard, w_sticky, w_round_up;
    logic [MAN_W-1:0] w_man;
    logic [MAN_W:0]   w_man_rnd;
    logic [c_xw-1:0]  w_exp_fin;
    logic             w_ovf, w_udf;
    logic [W-1:0]     w_y;

    assign w_norm = r_s2_prod[c_pw-1];

    always_comb begin
        w_man    = r_s2_prod[2*MAN_W-1 -: MAN_W];
        w_guard  = r_s2_prod[MAN_W-1];
        w_sticky = |r_s2_prod[MAN_W-2:0];
        if (w_norm) begin
            w_man    = r_s2_prod[2*MAN_W -: MAN_W];
            w_guard  = r_s2_prod[MAN_W];
            w_sticky = |r_s2_prod[MAN_W-1:0];
        end
    end

    assign w_round_up = w_guard & (w_sticky | w_man[0]);
    assign w_man_rnd  = {1'b0, w_man} + {{MAN_W{1'b0}}, w_round_up};
    // A carry out of rounding leaves the stored mantissa at zero; only the exponent moves.
    assign w_exp_fin  = r_s2_exp + c_xw'(w_norm) + c_xw'(w_man_rnd[MAN_W]);
    assign w_ovf      = ($signed(w_exp_fin) >= $signed(c_exp_max));
    assign w_udf      = w_exp_fin[c_xw-1] | (w_exp_fin == '0);

    always_comb begin
        w_y = {r_s2_sign, w_exp_fin[EXP_W-1:0], w_man_rnd[MAN_W-1:0]};
        case (r_s2_kind)
            c_kind_nan:  w_y = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            c_kind_inf:  w_y = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            c_kind_zero: w_y = {r_s2_sign, {(W-1){1'b0}}};
            default: begin
                if (w_ovf)
                    w_y = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (w_udf)
                    w_y = {r_s2_sign, {(W-1){1'b0}}};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
        end else if (!w_stall) begin
            r_s1_valid  <= in_valid;
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
            if (r_s2_valid)
                r_y <= w_y;
        end
    end

`ifdef FP_MUL_PIPE_FLAGS_EN
    logic       w_invalid;
    logic       r_s1_invalid, r_s2_invalid;
    logic [3:0] w_flags, r_flags;

    // Only signalling NaNs (quiet bit clear) raise invalid; quiet NaNs pass silently.
    assign w_invalid = w_inf_x_zero
                     | (w_a_nan & ~w_a_man[MAN_W-1])
                     | (w_b_nan & ~w_b_man[MAN_W-1]);

    always_comb begin
        w_flags = 4'b0000;
        case (r_s2_kind)
            c_kind_nan: w_flags[3] = r_s2_invalid;
            c_kind_num: begin
                if (w_ovf)
                    w_flags = 4'b0101;
                else if (w_udf)
                    w_flags = 4'b0011;
                else
                    w_flags[0] = w_guard | w_sticky;
            end
            default: w_flags = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (!w_stall) begin
            r_s1_invalid <= w_invalid;
            r_s2_invalid <= r_s1_invalid;
            if (r_s2_valid)
                r_flags <= w_flags;
        end
    end

    assign flags = r_flags;
`else
    assign flags = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_pipe
// Brief    : Scoreboard bench for fp_mul_pipe (single and half-size instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_pipe;

`ifdef FP_MUL_PIPE_FLAGS_EN
    localparam logic [3:0] c_flag_mask = 4'b1111;
`else
    localparam logic [3:0] c_flag_mask = 4'b0000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, y;
    logic [3:0]  flags;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [15:0] a2, b2, y2;
    logic [3:0]  flags2;

    always #5 clk = ~clk;

    fp_mul_pipe u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_half (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .y         (y2),
        .flags     (flags2)
    );

    typedef struct packed {
        logic [31:0] y;
        logic [3:0]  f;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        held   = 1'b0;
    logic [31:0] held_y;
    logic [3:0]  held_f;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output monitor and acceptance recorder, run once per cycle on the falling edge.
    task automatic sample();
        exp_t e;
        if (reset) begin
            q.delete();
            held = 1'b0;
        end else begin
            if (out_valid) begin
                if (held) begin
                    chk("hold_y", y, held_y);
                    chk("hold_flags", flags, held_f);
                end
                if (out_ready) begin
                    chk("result_expected", q.size() != 0, 1'b1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("y", y, e.y);
                        chk("flags", flags, e.f);
                    end
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    held_y = y;
                    held_f = flags;
                end
            end else begin
                held = 1'b0;
            end
            if (in_valid && in_ready)
                q.push_back(cur);
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [31:0] ia, input logic [31:0] ib,
                      input logic [31:0] ey, input logic [3:0] ef);
        a        = ia;
        b        = ib;
        cur      = '{y: ey, f: ef & c_flag_mask};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && q.size() != 0; k++)
            step();
        step();
        chk("drain_empty", q.size(), 0);
    endtask

    localparam int N_OPS = 14;
    logic [31:0] t_a  [N_OPS] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 32'hFF800000,
                                 32'h3F800001, 32'h3FC00001, 32'h3F800001, 32'h3F800003,
                                 32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h7F800000,
                                 32'h80000000, 32'hC0400000};
    logic [31:0] t_b  [N_OPS] = '{32'h7F000000, 32'h3F000000, 32'h80000000, 32'h40000000,
                                 32'h3F800001, 32'h3FC00001, 32'h3FC00000, 32'h3FC00000,
                                 32'h3F800000, 32'h3F800000, 32'hC0000000, 32'hFF800000,
                                 32'h80000000, 32'h40000000};
    logic [31:0] t_y  [N_OPS] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000,
                                 32'h3F800002, 32'h40100002, 32'h3FC00002, 32'h3FC00004,
                                 32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'hFF800000,
                                 32'h00000000, 32'hC0C00000};
    logic [3:0]  t_f  [N_OPS] = '{4'b0101, 4'b0011, 4'b1000, 4'b0000,
                                 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                 4'b0000, 4'b1000, 4'b0000, 4'b0000,
                                 4'b0000, 4'b0000};
    logic [31:0] s_b  [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        reset      = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        a2         = '0;
        b2         = '0;
        out_ready2 = 1'b1;
        cur        = '0;
        step();
        step();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_y", y, 32'h0);
        chk("reset_flags", flags, 4'h0);
        reset = 1'b0;
        step();

        // 2.0 x 3.0 with exact three-cycle latency
        a        = 32'h40000000;
        b        = 32'h40400000;
        cur      = '{y: 32'h40C00000, f: 4'b0000};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat_cycle1", out_valid, 1'b0);
        step();
        chk("lat_cycle2", out_valid, 1'b0);
        step();
        chk("lat_cycle3", out_valid, 1'b1);
        drain();

        // Directed special-value and rounding table, issued back to back
        for (int i = 0; i < N_OPS; i++)
            op(t_a[i], t_b[i], t_y[i], t_f[i]);
        drain();

        // Five-pair stream with the consumer stalling in cycles 4..6
        idx = 0;
        for (int cyc = 1; cyc <= 25 && (idx < 5 || q.size() != 0); cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            if (idx < 5) begin
                in_valid = 1'b1;
                a        = 32'h3F800000;
                b        = s_b[idx];
                cur      = '{y: s_b[idx], f: 4'b0000};
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc <= 8)
                chk("stall_in_ready", in_ready, (cyc < 4 || cyc > 6));
            if (cyc == 4)
                chk("stall_first_out", out_valid, 1'b1);
            if (in_valid && in_ready)
                idx++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three results in flight: none may surface afterwards
        op(32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
        op(32'h3F800000, 32'h40000000, 32'h40000000, 4'b0000);
        op(32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("post_reset_y", y, 32'h0);
        for (int k = 0; k < 6; k++) begin
            chk("post_reset_quiet", out_valid, 1'b0);
            step();
        end
        op(32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);
        drain();

        // Half-precision instance
        a2        = 16'h4000;
        b2        = 16'h4200;
        in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        step();
        chk("half_lat_cycle2", out_valid2, 1'b0);
        step();
        chk("half_valid", out_valid2, 1'b1);
        chk("half_y", y2, 16'h4600);
        chk("half_flags", flags2, 4'b0000);
        a2        = 16'h7800;
        b2        = 16'h7800;
        in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        step();
        step();
        chk("half_ovf_valid", out_valid2, 1'b1);
        chk("half_ovf_y", y2, 16'h7C00);
        chk("half_ovf_flags", flags2, 4'b0101 & c_flag_mask);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
